// File: rtl/vcve2_instr_aligner.sv
// Instruction aligner: turns word-aligned 32-bit fetch words into a stream of
// 16/32-bit instructions with halfword PCs, keeping one residual halfword so
// that 32-bit instructions straddling a word boundary can be reassembled.
module vcve2_instr_aligner #(
  parameter bit AssertEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_is_compressed_o,
  output logic        instr_err_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    SKIP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] resid_q, resid_d;
  logic [31:0] resid_addr_q, resid_addr_d;

  logic [15:0] lo, hi;
  logic [31:0] addr_a, addr_a2;
  logic        unused_addr_bits;

  assign lo      = fetch_rdata_i[15:0];
  assign hi      = fetch_rdata_i[31:16];
  assign addr_a  = {fetch_addr_i[31:2], 2'b00};
  assign addr_a2 = addr_a + 32'd2;

  // Sub-halfword address bits carry no information for this block.
  assign unused_addr_bits = ^{fetch_addr_i[1:0], branch_addr_i[0]};

  function automatic logic is_c(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  // Slot selection, output muxing and next-state computation.
  always_comb begin
    state_d       = state_q;
    resid_d       = resid_q;
    resid_addr_d  = resid_addr_q;
    instr_valid_o = 1'b0;
    fetch_ready_o = 1'b0;
    instr_rdata_o = 32'h0;
    instr_addr_o  = 32'h0;
    instr_err_o   = 1'b0;

    if (rst_i) begin
      state_d = state_q;
    end else if (branch_i) begin
      state_d      = branch_addr_i[1] ? SKIP : EMPTY;
      resid_d      = 16'h0;
      resid_addr_d = 32'h0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (fetch_valid_i) begin
            instr_valid_o = 1'b1;
            instr_addr_o  = addr_a;
            fetch_ready_o = instr_ready_i;
            if (fetch_err_i) begin
              instr_err_o   = 1'b1;
              instr_rdata_o = fetch_rdata_i;
            end else if (is_c(lo)) begin
              instr_rdata_o = {16'h0, lo};
              if (instr_ready_i) begin
                resid_d      = hi;
                resid_addr_d = addr_a2;
                state_d      = HALF;
              end
            end else begin
              instr_rdata_o = fetch_rdata_i;
            end
          end
        end
        HALF: begin
          if (is_c(resid_q)) begin
            instr_valid_o = 1'b1;
            instr_rdata_o = {16'h0, resid_q};
            instr_addr_o  = resid_addr_q;
            if (instr_ready_i) state_d = EMPTY;
          end else if (fetch_valid_i) begin
            instr_valid_o = 1'b1;
            instr_addr_o  = resid_addr_q;
            fetch_ready_o = instr_ready_i;
            if (fetch_err_i) begin
              instr_err_o   = 1'b1;
              instr_rdata_o = fetch_rdata_i;
              if (instr_ready_i) state_d = EMPTY;
            end else begin
              instr_rdata_o = {lo, resid_q};
              if (instr_ready_i) begin
                resid_d      = hi;
                resid_addr_d = addr_a2;
              end
            end
          end
        end
        SKIP: begin
          if (fetch_valid_i) begin
            if (fetch_err_i || is_c(hi)) begin
              instr_valid_o = 1'b1;
              instr_addr_o  = addr_a2;
              fetch_ready_o = instr_ready_i;
              instr_err_o   = fetch_err_i;
              instr_rdata_o = fetch_err_i ? fetch_rdata_i : {16'h0, hi};
              if (instr_ready_i) state_d = EMPTY;
            end else begin
              // Uncompressed upper half: absorb it as the residual, no offer.
              fetch_ready_o = 1'b1;
              resid_d       = hi;
              resid_addr_d  = addr_a2;
              state_d       = HALF;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    instr_is_compressed_o = instr_valid_o && !instr_err_o && (instr_rdata_o[1:0] != 2'b11);
  end

  // State and residual registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      resid_q      <= 16'h0;
      resid_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      resid_q      <= resid_d;
      resid_addr_q <= resid_addr_d;
    end
  end

  if (AssertEn) begin : g_assert
    a_rdata_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (instr_valid_o && !instr_ready_i && !branch_i) |=> (branch_i || $stable(instr_rdata_o)));
    a_ready_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
      fetch_ready_o |-> fetch_valid_i);
  end

endmodule

// File: tb/tb_vcve2_instr_aligner.sv
// Testbench for vcve2_instr_aligner: directed scenarios followed by a random
// fetch-unit / decoder environment checked against a PC-based model.
module tb_vcve2_instr_aligner;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetchValid;
   logic [31:0] fetchRdata;
   logic [31:0] fetchAddr;
   logic        fetchErr;
   logic        fetchReady;
   logic        branch;
   logic [31:0] branchAddr;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] instrRdata;
   logic [31:0] instrAddr;
   logic        instrIsCompressed;
   logic        instrErr;

   int vecCount  = 0;
   int missCount = 0;

   // Model: PC of the next instruction, plus a halfword already taken from a consumed word.
   logic [31:0] mPc;
   logic        mHave;
   logic [15:0] mHw;
   logic        expFr;

   // Random fetch unit state.
   logic [31:0] fuAddr;
   logic [31:0] fuWord;
   logic        fuErr;
   logic        fuValid;

   always #5 clk = ~clk;

   vcve2_instr_aligner #(.AssertEn(1'b1)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .fetch_valid_i         (fetchValid),
      .fetch_rdata_i         (fetchRdata),
      .fetch_addr_i          (fetchAddr),
      .fetch_err_i           (fetchErr),
      .fetch_ready_o         (fetchReady),
      .branch_i              (branch),
      .branch_addr_i         (branchAddr),
      .instr_valid_o         (instrValid),
      .instr_ready_i         (instrReady),
      .instr_rdata_o         (instrRdata),
      .instr_addr_o          (instrAddr),
      .instr_is_compressed_o (instrIsCompressed),
      .instr_err_o           (instrErr)
   );

   function automatic logic isC(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // All outputs must be zero while reset is held.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, {31'b0, instrValid}, 32'h0);
      checkOutput({tag, "_fready"}, {31'b0, fetchReady}, 32'h0);
      checkOutput({tag, "_rdata"}, instrRdata, 32'h0);
      checkOutput({tag, "_addr"}, instrAddr, 32'h0);
      checkOutput({tag, "_err"}, {31'b0, instrErr}, 32'h0);
      checkOutput({tag, "_isc"}, {31'b0, instrIsCompressed}, 32'h0);
   endtask

   // Drive one cycle, predict outputs from the model, compare, advance the model.
   task automatic applyStimulus(input logic fv, input logic [31:0] rd, input logic [31:0] ad,
                                input logic er, input logic br, input logic [31:0] ba,
                                input logic rdy);
      logic [31:0] a, ed, ea, nPc;
      logic [15:0] lo, hi, nHw;
      logic        ev, ee, ec, nHave;
      @(negedge clk);
      fetchValid = fv; fetchRdata = rd; fetchAddr = ad; fetchErr = er;
      branch = br; branchAddr = ba; instrReady = rdy;
      #1;
      a  = {ad[31:2], 2'b00};
      lo = rd[15:0];
      hi = rd[31:16];
      ev = 1'b0; ee = 1'b0; ed = 32'h0; ea = 32'h0; expFr = 1'b0;
      nPc = mPc; nHave = mHave; nHw = mHw;
      if (br) begin
         nPc = {ba[31:1], 1'b0};
         nHave = 1'b0;
      end else if (mHave && isC(mHw)) begin
         ev = 1'b1; ed = {16'h0, mHw}; ea = mPc;
         if (rdy) begin nHave = 1'b0; nPc = mPc + 32'd2; end
      end else if (fv) begin
         if (mHave) ea = mPc;
         else if (mPc[1]) ea = a + 32'd2;
         else ea = a;
         if (er) begin
            ev = 1'b1; ee = 1'b1; ed = rd; expFr = rdy;
            if (rdy) begin nHave = 1'b0; nPc = a + 32'd4; end
         end else if (mHave) begin
            ev = 1'b1; ed = {lo, mHw}; expFr = rdy;
            if (rdy) begin nHave = 1'b1; nHw = hi; nPc = a + 32'd2; end
         end else if (!mPc[1]) begin
            ev = 1'b1; expFr = rdy;
            if (isC(lo)) begin
               ed = {16'h0, lo};
               if (rdy) begin nHave = 1'b1; nHw = hi; nPc = a + 32'd2; end
            end else begin
               ed = rd;
               if (rdy) nPc = a + 32'd4;
            end
         end else if (isC(hi)) begin
            ev = 1'b1; ed = {16'h0, hi}; expFr = rdy;
            if (rdy) nPc = a + 32'd4;
         end else begin
            ea = 32'h0; expFr = 1'b1;
            nHave = 1'b1; nHw = hi; nPc = a + 32'd2;
         end
      end
      ec = ev && !ee && (ed[1:0] != 2'b11);
      checkOutput("valid", {31'b0, instrValid}, {31'b0, ev});
      checkOutput("fetch_ready", {31'b0, fetchReady}, {31'b0, expFr});
      checkOutput("rdata", instrRdata, ed);
      checkOutput("addr", instrAddr, ea);
      checkOutput("is_compressed", {31'b0, instrIsCompressed}, {31'b0, ec});
      checkOutput("err", {31'b0, instrErr}, {31'b0, ee});
      mPc = nPc; mHave = nHave; mHw = nHw;
   endtask

   function automatic logic [15:0] randHalf();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 0) h[1:0] = 2'b11;
      else h[1:0] = 2'($urandom_range(0, 2));
      return h;
   endfunction

   task automatic newFetchWord();
      fuWord  = {randHalf(), randHalf()};
      fuErr   = ($urandom_range(0, 19) == 0);
      fuValid = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      rst = 1'b1;
      fetchValid = 1'b1; fetchRdata = 32'h0040_0513; fetchAddr = 32'h0;
      fetchErr = 1'b0; branch = 1'b0; branchAddr = 32'h0; instrReady = 1'b1;
      mPc = 32'h0; mHave = 1'b0; mHw = 16'h0; expFr = 1'b0;
      @(negedge clk); #1;
      checkResetOutputs("reset");
      @(negedge clk);
      fetchValid = 1'b0; instrReady = 1'b0;
      rst = 1'b0;

      // Two compressed halves in one word.
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1);
      applyStimulus(1'b1, 32'h0001_4501, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h104, 1'b0, 1'b0, 32'h0, 1'b1);

      // Compressed lo, then a 32-bit instruction straddling two words.
      applyStimulus(1'b1, 32'h0093_4505, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h0000_0010, 32'h204, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h208, 1'b0, 1'b0, 32'h0, 1'b1);

      // Branch to an odd-halfword target, compressed and uncompressed upper half.
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h302, 1'b1);
      applyStimulus(1'b1, 32'h4581_ABCD, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h0040_0513, 32'h304, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h302, 1'b1);
      applyStimulus(1'b1, 32'h0513_ABCD, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h00C8_1234, 32'h304, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h308, 1'b0, 1'b0, 32'h0, 1'b1);

      // Back-pressure on an uncompressed word.
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b1);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 32'h0050_0593, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h0050_0593, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1);

      // Uncompressed residual followed by an errored word.
      applyStimulus(1'b1, 32'h0593_4505, 32'h500, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h504, 1'b1, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h0000_0013, 32'h508, 1'b0, 1'b0, 32'h0, 1'b1);

      // Address wrap at the top of the address space.
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
      applyStimulus(1'b1, 32'h4501_0000, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
      applyStimulus(1'b1, 32'h0513_0000, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h0593_0001, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

      // Reset while holding an uncompressed residual.
      @(negedge clk);
      fetchValid = 1'b1; fetchRdata = 32'h1234_5678; fetchAddr = 32'h4;
      fetchErr = 1'b0; branch = 1'b0; instrReady = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checkResetOutputs("midreset");
      @(negedge clk);
      fetchValid = 1'b0; instrReady = 1'b0;
      rst = 1'b0;
      mPc = 32'h0; mHave = 1'b0; mHw = 16'h0;
      applyStimulus(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

      // Random environment: a fetch unit that holds words until consumed.
      fuAddr = 32'h4;
      newFetchWord();
      for (int n = 0; n < 4000; n++) begin
         logic        br, rdy;
         logic [31:0] ba;
         br  = ($urandom_range(0, 15) == 0) || (n == 0);
         ba  = ($urandom_range(0, 3) == 0) ? {28'hFFFF_FFF, 4'($urandom)} : $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         applyStimulus(fuValid, fuWord, fuAddr, fuErr, br, ba, rdy);
         if (br) begin
            fuAddr = {ba[31:2], 2'b00};
            newFetchWord();
         end else if (fuValid && expFr) begin
            fuAddr = fuAddr + 32'd4;
            newFetchWord();
         end else if (!fuValid) begin
            fuValid = ($urandom_range(0, 2) != 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
